// File: rtl/inst_mem_boot_pkg.sv
// Shared types and constants for the boot-loading instruction memory.
// Also provides the instruction-width and NOP macros that sit beside INST_ADD_WIDTH.
`ifndef INST_ADD_WIDTH
`define INST_ADD_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NOP
`define NOP 32'h0
`endif

package inst_mem_boot_pkg;
    localparam int          INST_W   = `INST_WIDTH;
    localparam logic [31:0] NOP_INST = `NOP;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/inst_mem_boot_packer.sv
// Packs loader bytes big-endian into 32-bit words, zero-filling a short final word.
// Latency: word_vld is combinational with the completing byte; no backpressure, caller gates byte_vld.
module byte_packer
    import inst_mem_boot_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    input  logic              byte_last,
    output logic [INST_W-1:0] word_dat,
    output logic              word_vld
);
    logic [1:0]        cnt_q, cnt_d;
    logic [INST_W-1:0] shift_q, shift_d;
    logic [INST_W-1:0] shifted;

    always_comb begin
        shifted  = {shift_q[23:0], byte_dat};
        word_vld = byte_vld && (byte_last || cnt_q == 2'd3);
        // Left-align the partial word so unfilled low bytes read as zero.
        case (cnt_q)
            2'd0:    word_dat = {shifted[7:0], 24'h0};
            2'd1:    word_dat = {shifted[15:0], 16'h0};
            2'd2:    word_dat = {shifted[23:0], 8'h0};
            default: word_dat = shifted;
        endcase
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (word_vld) begin
            cnt_d   = 2'd0;
            shift_d = '0;
        end else if (byte_vld) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = shifted;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/inst_mem_boot.sv
// Instruction memory with boot loader: fills words from a byte stream, then serves PC reads.
// Latency: writes on the accepting edge, reads are combinational; LD_READY drops for good once in RUN.
module inst_mem_boot
    import inst_mem_boot_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = `INST_ADD_WIDTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [AW-1:0]     PC,
    input  logic              LD_VALID,
    input  logic [7:0]        LD_BYTE,
    input  logic              LD_LAST,
    output logic              LD_READY,
    output logic [INST_W-1:0] INSTR,
    output logic              BOOT_DONE,
    output logic              ADDR_ERR,
    output logic              LD_OVF
);
    localparam int            IW       = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] PC_LIMIT = AW'(4 * DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [IW-1:0]     wptr_q, wptr_d;
    logic              ovf_q, ovf_d;
    logic              accept;
    logic              word_vld;
    logic [INST_W-1:0] word_dat;
    logic [INST_W-1:0] mem [DEPTH_WORDS];
    logic [IW-1:0]     rd_idx;

    assign LD_READY  = (state_q == ST_LOAD);
    assign BOOT_DONE = (state_q == ST_RUN);
    assign LD_OVF    = ovf_q;
    assign accept    = LD_VALID && LD_READY;

    byte_packer u_packer (
        .CLK      (CLK),
        .RST      (RST),
        .byte_vld (accept),
        .byte_dat (LD_BYTE),
        .byte_last(LD_LAST),
        .word_dat (word_dat),
        .word_vld (word_vld)
    );

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        ovf_d   = ovf_q;
        if (word_vld) begin
            wptr_d = wptr_q + IW'(1);
            if (LD_LAST) begin
                state_d = ST_RUN;
            end else if (wptr_q == IW'(DEPTH_WORDS - 1)) begin
                // Image does not fit: stop here rather than wrap onto word 0.
                state_d = ST_RUN;
                ovf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_LOAD;
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (word_vld) begin
            mem[wptr_q] <= word_dat;
        end
    end

    always_comb begin
        rd_idx   = PC[IW+1:2];
        ADDR_ERR = BOOT_DONE && (PC[1:0] != 2'b00 || PC >= PC_LIMIT);
        INSTR    = (BOOT_DONE && !ADDR_ERR) ? mem[rd_idx] : NOP_INST;
    end
endmodule
